// File: rtl/sht40_measure_sequencer.sv
// sht40_measure_sequencer: runs one SHT40 high-precision measurement (write 0xFD, wait, read 6 bytes)
// through the I2C byte engine. Build option: define SHT40_CRC_CHECK_EN to verify each word's CRC-8.
module sht40_measure_sequencer #(
  parameter logic [6:0]  DEV_ADDR    = 7'h44,
  parameter logic [7:0]  MEAS_CMD    = 8'hFD,
  parameter int unsigned WAIT_CYCLES = 100000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        nack_err,
  output logic        crc_err,
  output logic [15:0] temp_raw,
  output logic [15:0] rh_raw,
  output logic        i2c_cmd_valid,
  input  logic        i2c_cmd_ready,
  output logic [1:0]  i2c_cmd_op,
  output logic [7:0]  i2c_cmd_byte,
  output logic        i2c_cmd_ack,
  input  logic        i2c_rsp_valid,
  input  logic        i2c_rsp_nack,
  input  logic [7:0]  i2c_rsp_data
);
  localparam int WAIT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] OP_START_WR = 2'b00;
  localparam logic [1:0] OP_WR       = 2'b01;
  localparam logic [1:0] OP_RD       = 2'b10;
  localparam logic [1:0] OP_STOP     = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_W_ADDR, S_W_CMD, S_W_STOP, S_WAIT, S_R_ADDR,
    S_R_BYTE, S_R_STOP, S_E_STOP, S_CHECK, S_DONE
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
    logic       ack;
  } cmd_t;

  function automatic cmd_t mk_cmd(input logic [1:0] op, input logic [7:0] data, input logic ack);
    return '{op: op, data: data, ack: ack};
  endfunction

  state_t             state;
  cmd_t               cmd;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [RETRY_W-1:0] retry;
  logic [2:0]         byte_cnt;
  logic               cmd_nacked;
  logic [7:0]         rx [6];
  logic               rsp_fire;
  logic               crc_ok;

  assign i2c_cmd_op   = cmd.op;
  assign i2c_cmd_byte = cmd.data;
  assign i2c_cmd_ack  = cmd.ack;

  // A response is only meaningful once the op has left the request register.
  assign rsp_fire = i2c_rsp_valid && !i2c_cmd_valid;

`ifdef SHT40_CRC_CHECK_EN
  function automatic logic [7:0] crc8(input logic [15:0] word);
    logic [7:0] crc;
    // NOTE: blocking assignments are right here: these are function-local temporaries, not state.
    crc = 8'hFF;
    for (int i = 15; i >= 0; i--)
      crc = (crc[7] ^ word[i]) ? ({crc[6:0], 1'b0} ^ 8'h31) : {crc[6:0], 1'b0};
    return crc;
  endfunction

  assign crc_ok = (crc8({rx[0], rx[1]}) == rx[2]) && (crc8({rx[3], rx[4]}) == rx[5]);
`else
  assign crc_ok = 1'b1;
`endif

  // NOTE: the receive buffer is plain storage rewritten before every CHECK, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == S_R_BYTE && rsp_fire) rx[byte_cnt] <= i2c_rsp_data;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      nack_err      <= 1'b0;
      crc_err       <= 1'b0;
      temp_raw      <= '0;
      rh_raw        <= '0;
      i2c_cmd_valid <= 1'b0;
      cmd           <= '0;
      wait_cnt      <= '0;
      retry         <= '0;
      byte_cnt      <= '0;
      cmd_nacked    <= 1'b0;
    end else begin
      done     <= 1'b0;
      nack_err <= 1'b0;
      crc_err  <= 1'b0;
      if (i2c_cmd_valid && i2c_cmd_ready) i2c_cmd_valid <= 1'b0;

      case (state)
        S_IDLE: if (start) begin
          busy          <= 1'b1;
          state         <= S_W_ADDR;
          cmd           <= mk_cmd(OP_START_WR, {DEV_ADDR, 1'b0}, 1'b0);
          i2c_cmd_valid <= 1'b1;
        end
        S_W_ADDR: if (rsp_fire) begin
          state         <= i2c_rsp_nack ? S_E_STOP : S_W_CMD;
          cmd           <= i2c_rsp_nack ? mk_cmd(OP_STOP, 8'h00, 1'b0) : mk_cmd(OP_WR, MEAS_CMD, 1'b0);
          i2c_cmd_valid <= 1'b1;
        end
        S_W_CMD: if (rsp_fire) begin
          // A rejected command is a sensor fault, not a bus collision: stop and report without retrying.
          cmd_nacked    <= i2c_rsp_nack;
          state         <= i2c_rsp_nack ? S_E_STOP : S_W_STOP;
          cmd           <= mk_cmd(OP_STOP, 8'h00, 1'b0);
          i2c_cmd_valid <= 1'b1;
        end
        S_W_STOP: if (rsp_fire) begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_W'(WAIT_CYCLES - 1)) begin
            state         <= S_R_ADDR;
            cmd           <= mk_cmd(OP_START_WR, {DEV_ADDR, 1'b1}, 1'b0);
            i2c_cmd_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_R_ADDR: if (rsp_fire) begin
          byte_cnt      <= '0;
          state         <= i2c_rsp_nack ? S_E_STOP : S_R_BYTE;
          cmd           <= i2c_rsp_nack ? mk_cmd(OP_STOP, 8'h00, 1'b0) : mk_cmd(OP_RD, 8'h00, 1'b1);
          i2c_cmd_valid <= 1'b1;
        end
        S_R_BYTE: if (rsp_fire) begin
          if (byte_cnt == 3'd5) begin
            state <= S_R_STOP;
            cmd   <= mk_cmd(OP_STOP, 8'h00, 1'b0);
          end else begin
            // The final byte is NACKed by the master to end the read burst.
            byte_cnt <= byte_cnt + 1'b1;
            cmd      <= mk_cmd(OP_RD, 8'h00, byte_cnt != 3'd4);
          end
          i2c_cmd_valid <= 1'b1;
        end
        S_R_STOP: if (rsp_fire) state <= S_CHECK;
        S_E_STOP: if (rsp_fire) begin
          if (cmd_nacked || retry == RETRY_W'(MAX_RETRY)) begin
            done     <= 1'b1;
            nack_err <= 1'b1;
            state    <= S_DONE;
          end else begin
            retry         <= retry + 1'b1;
            state         <= S_W_ADDR;
            cmd           <= mk_cmd(OP_START_WR, {DEV_ADDR, 1'b0}, 1'b0);
            i2c_cmd_valid <= 1'b1;
          end
        end
        S_CHECK: begin
          done    <= 1'b1;
          crc_err <= !crc_ok;
          if (crc_ok) begin
            temp_raw <= {rx[0], rx[1]};
            rh_raw   <= {rx[3], rx[4]};
          end
          state <= S_DONE;
        end
        S_DONE: begin
          busy       <= 1'b0;
          retry      <= '0;
          cmd_nacked <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sht40_measure_sequencer.sv
// Bench for sht40_measure_sequencer: scripted I2C slave model plus op/result scoreboards.
module tb_sht40_measure_sequencer;
  localparam int WAIT_CYCLES = 20;
  localparam int MAX_RETRY   = 2;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, nack_err, crc_err;
  logic [15:0] temp_raw, rh_raw;
  logic        i2c_cmd_valid, i2c_cmd_ready, i2c_cmd_ack;
  logic [1:0]  i2c_cmd_op;
  logic [7:0]  i2c_cmd_byte;
  logic        i2c_rsp_valid, i2c_rsp_nack;
  logic [7:0]  i2c_rsp_data;

  always #5 clk = ~clk;

  sht40_measure_sequencer #(.WAIT_CYCLES(WAIT_CYCLES), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .nack_err(nack_err), .crc_err(crc_err), .temp_raw(temp_raw), .rh_raw(rh_raw),
    .i2c_cmd_valid(i2c_cmd_valid), .i2c_cmd_ready(i2c_cmd_ready), .i2c_cmd_op(i2c_cmd_op),
    .i2c_cmd_byte(i2c_cmd_byte), .i2c_cmd_ack(i2c_cmd_ack), .i2c_rsp_valid(i2c_rsp_valid),
    .i2c_rsp_nack(i2c_rsp_nack), .i2c_rsp_data(i2c_rsp_data)
  );

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
    logic       ack;
  } op_t;

  typedef struct packed {
    logic        nack_err;
    logic        crc_err;
    logic [15:0] temp;
    logic [15:0] rh;
  } res_t;

  op_t         exp_ops[$];
  res_t        exp_res[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  logic [15:0] exp_temp = 16'h0000;
  logic [15:0] exp_rh   = 16'h0000;

  // Slave model state
  logic [7:0]  rd_data [6];
  int          rd_idx = 0;
  int          nack_waddr = 0;
  bit          nack_cmd = 0;
  int          dly = 0;
  bit          pend_nack;
  logic [7:0]  pend_data;
  bit          cmd_acked = 0, is_wstop = 0, wait_armed = 0, prev_valid = 0;
  int unsigned rsp_edge = 0;
  op_t         got;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] c;
    c = 8'hFF ^ a;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    c = c ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    return c;
  endfunction

  function automatic op_t mk(input logic [1:0] op, input logic [7:0] d, input logic a);
    return '{op: op, data: d, ack: a};
  endfunction

  task automatic set_frame(input logic [7:0] b0, b1, b2, b3, b4, b5);
    rd_data[0] = b0; rd_data[1] = b1; rd_data[2] = b2;
    rd_data[3] = b3; rd_data[4] = b4; rd_data[5] = b5;
  endtask

  task automatic set_good(input logic [15:0] t, input logic [15:0] h);
    set_frame(t[15:8], t[7:0], crc8(t[15:8], t[7:0]), h[15:8], h[7:0], crc8(h[15:8], h[7:0]));
  endtask

  task automatic push_attempt_nack();
    exp_ops.push_back(mk(2'b00, 8'h88, 1'b0));
    exp_ops.push_back(mk(2'b11, 8'h00, 1'b0));
  endtask

  task automatic push_full_ok();
    exp_ops.push_back(mk(2'b00, 8'h88, 1'b0));
    exp_ops.push_back(mk(2'b01, 8'hFD, 1'b0));
    exp_ops.push_back(mk(2'b11, 8'h00, 1'b0));
    exp_ops.push_back(mk(2'b00, 8'h89, 1'b0));
    for (int i = 0; i < 6; i++) exp_ops.push_back(mk(2'b10, 8'h00, i < 5));
    exp_ops.push_back(mk(2'b11, 8'h00, 1'b0));
  endtask

  // Expected outcome of a transaction that reaches CHECK with the current frame.
  task automatic push_read_result();
    bit good;
    good = (crc8(rd_data[0], rd_data[1]) == rd_data[2]) && (crc8(rd_data[3], rd_data[4]) == rd_data[5]);
`ifdef SHT40_CRC_CHECK_EN
    if (good) begin
      exp_temp = {rd_data[0], rd_data[1]};
      exp_rh   = {rd_data[3], rd_data[4]};
    end
    exp_res.push_back('{nack_err: 1'b0, crc_err: !good, temp: exp_temp, rh: exp_rh});
`else
    exp_temp = {rd_data[0], rd_data[1]};
    exp_rh   = {rd_data[3], rd_data[4]};
    exp_res.push_back('{nack_err: 1'b0, crc_err: 1'b0, temp: exp_temp, rh: exp_rh});
`endif
  endtask

  task automatic push_nack_result();
    exp_res.push_back('{nack_err: 1'b1, crc_err: 1'b0, temp: exp_temp, rh: exp_rh});
  endtask

  task automatic pulse_start();
    rd_idx = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_on_start", busy, 1'b1);
  endtask

  // Waits for done, scores it, and optionally pokes start while busy and on the done cycle.
  task automatic wait_done(input bit poke);
    bit   seen;
    res_t r;
    seen = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start = poke && (n == 6);
      if (done) begin
        if (exp_res.size() == 0) check("unexpected_done", 0, 1);
        else begin
          r = exp_res.pop_front();
          check("nack_err", nack_err, r.nack_err);
          check("crc_err", crc_err, r.crc_err);
          check("temp_raw", temp_raw, r.temp);
          check("rh_raw", rh_raw, r.rh);
        end
        check("busy_in_done", busy, 1'b1);
        start = poke;
        seen  = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", {busy, done, nack_err, crc_err}, 4'b0000);
    repeat (3) @(negedge clk);
    check("stays_idle", {busy, i2c_cmd_valid}, 2'b00);
    check("ops_drained", exp_ops.size(), 0);
    exp_ops.delete();
    exp_res.delete();
  endtask

  // I2C slave model: scores each accepted op and answers two cycles later.
  initial begin
    i2c_rsp_valid = 1'b0; i2c_rsp_nack = 1'b0; i2c_rsp_data = 8'h00;
    forever begin
      @(negedge clk);
      i2c_rsp_valid = 1'b0; i2c_rsp_nack = 1'b0; i2c_rsp_data = 8'h00;
      if (rst) begin
        dly = 0; wait_armed = 0; prev_valid = 0; cmd_acked = 0; is_wstop = 0;
        continue;
      end
      // Edge count from the STOP response being sampled to the read-address request appearing.
      if (i2c_cmd_valid && !prev_valid && wait_armed) begin
        check("wait_len", cyc - rsp_edge, WAIT_CYCLES);
        wait_armed = 0;
      end
      prev_valid = i2c_cmd_valid;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          i2c_rsp_valid = 1'b1; i2c_rsp_nack = pend_nack; i2c_rsp_data = pend_data;
          if (is_wstop) begin
            rsp_edge = cyc + 1; wait_armed = 1; is_wstop = 0;
          end
        end
      end
      if (i2c_cmd_valid && i2c_cmd_ready) begin
        got = '{op: i2c_cmd_op, data: i2c_cmd_byte, ack: i2c_cmd_ack};
        if (exp_ops.size() == 0) check("unexpected_op", exp_ops.size(), 1);
        else check("op", got, exp_ops.pop_front());
        pend_nack = 0; pend_data = 8'h00;
        case (i2c_cmd_op)
          2'b00: if (i2c_cmd_byte == 8'h88 && nack_waddr > 0) begin pend_nack = 1; nack_waddr--; end
          2'b01: begin pend_nack = nack_cmd; cmd_acked = !nack_cmd; end
          2'b10: begin
            pend_data = (rd_idx < 6) ? rd_data[rd_idx] : 8'h00;
            rd_idx++;
          end
          default: begin is_wstop = cmd_acked; cmd_acked = 0; end
        endcase
        dly = 2;
      end
    end
  end

  initial begin
    op_t held;
    rst = 1'b1; start = 1'b0; i2c_cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_flags", {busy, done, nack_err, crc_err, i2c_cmd_valid}, 5'b00000);
    check("rst_cmd", {i2c_cmd_op, i2c_cmd_byte, i2c_cmd_ack}, 11'h000);
    check("rst_raw", {temp_raw, rh_raw}, 32'h0);
    rst = 1'b0;

    // Nominal read of the reference frame.
    set_frame(8'hBE, 8'hEF, 8'h92, 8'h66, 8'h66, 8'h93);
    push_full_ok(); push_read_result();
    pulse_start(); wait_done(1'b0);

    // Fresh good words so a rejected frame is distinguishable from a published one.
    set_good(16'h5A17, 16'h3C42);
    push_full_ok(); push_read_result();
    pulse_start(); wait_done(1'b0);

    // Bad temperature CRC, then bad humidity CRC.
    set_frame(8'hBE, 8'hEF, 8'h93, 8'h66, 8'h66, 8'h93);
    push_full_ok(); push_read_result();
    pulse_start(); wait_done(1'b0);
    set_good(16'h7001, 16'h0E0F);
    rd_data[5] = rd_data[5] ^ 8'h01;
    push_full_ok(); push_read_result();
    pulse_start(); wait_done(1'b0);

    // Address NACK on every attempt, then two NACKs followed by success.
    set_good(16'h1234, 16'hABCD);
    nack_waddr = 3;
    for (int i = 0; i <= MAX_RETRY; i++) push_attempt_nack();
    push_nack_result();
    pulse_start(); wait_done(1'b0);
    nack_waddr = 2;
    push_attempt_nack(); push_attempt_nack(); push_full_ok(); push_read_result();
    pulse_start(); wait_done(1'b0);

    // Command NACK: single STOP, no retry.
    nack_cmd = 1;
    exp_ops.push_back(mk(2'b00, 8'h88, 1'b0));
    exp_ops.push_back(mk(2'b01, 8'hFD, 1'b0));
    exp_ops.push_back(mk(2'b11, 8'h00, 1'b0));
    push_nack_result();
    pulse_start(); wait_done(1'b0);
    nack_cmd = 0;

    // start pulses while busy and on the done cycle are ignored.
    set_good(16'hC0DE, 16'h0420);
    push_full_ok(); push_read_result();
    pulse_start(); wait_done(1'b1);

    // Reset in the middle of the read burst.
    set_good(16'h1357, 16'h2468);
    push_full_ok();
    pulse_start();
    for (int n = 0; n < 500 && rd_idx < 3; n++) @(negedge clk);
    check("reached_rbyte", rd_idx >= 3, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_flags", {busy, done, nack_err, crc_err, i2c_cmd_valid}, 5'b00000);
    check("midrst_cmd", {i2c_cmd_op, i2c_cmd_byte, i2c_cmd_ack}, 11'h000);
    check("midrst_raw", {temp_raw, rh_raw}, 32'h0);
    rst = 1'b0;
    exp_ops.delete(); exp_res.delete();
    exp_temp = 16'h0000; exp_rh = 16'h0000;

    // Master stalls the first op for 10 cycles; request must hold steady.
    set_good(16'h0BAD, 16'hF00D);
    push_full_ok(); push_read_result();
    i2c_cmd_ready = 1'b0;
    pulse_start();
    for (int n = 0; n < 10 && !i2c_cmd_valid; n++) @(negedge clk);
    held = '{op: i2c_cmd_op, data: i2c_cmd_byte, ack: i2c_cmd_ack};
    check("held_first_op", held, mk(2'b00, 8'h88, 1'b0));
    repeat (10) begin
      @(negedge clk);
      check("hold_stable", {i2c_cmd_valid, i2c_cmd_op, i2c_cmd_byte, i2c_cmd_ack}, {1'b1, held});
    end
    @(posedge clk); #1 i2c_cmd_ready = 1'b1;
    wait_done(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
